// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes U/J/I/B/S immediates at push
// time and buffers {imm, fmt, illegal, tag} in a 2-entry FIFO toward decode.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned DEPTH = 2;

  localparam logic [4:0] FMT_U = 5'b10000;
  localparam logic [4:0] FMT_J = 5'b01000;
  localparam logic [4:0] FMT_I = 5'b00100;
  localparam logic [4:0] FMT_B = 5'b00010;
  localparam logic [4:0] FMT_S = 5'b00001;

  logic [XLEN-1:0]  imm_q  [DEPTH];
  logic [4:0]       fmt_q  [DEPTH];
  logic             ill_q  [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic             push;
  logic             pop;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]  dec_imm;
  logic [4:0]       dec_fmt;
  logic             dec_ill;
  logic             s;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign s         = in_inst[31];

  // Decode to a 32-bit signed immediate; every format sign-extends from bit 31.
  always_comb begin
    imm32   = '0;
    dec_fmt = '0;
    dec_ill = 1'b0;
    if (in_inst[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (in_inst[6:2])
        5'b01101, 5'b00101: begin
          imm32   = {in_inst[31:12], 12'b0};
          dec_fmt = FMT_U;
        end
        5'b11011: begin
          imm32   = {{12{s}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
          dec_fmt = FMT_J;
        end
        5'b11001, 5'b00000, 5'b00100: begin
          imm32   = {{20{s}}, in_inst[31:20]};
          dec_fmt = FMT_I;
        end
        5'b11000: begin
          imm32   = {{20{s}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
          dec_fmt = FMT_B;
        end
        5'b01000: begin
          imm32   = {{20{s}}, in_inst[31:25], in_inst[11:7]};
          dec_fmt = FMT_S;
        end
        default: dec_ill = 1'b1;
      endcase
    end
    dec_imm = XLEN'(imm32);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= '0;
        ill_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      if (push) begin
        imm_q[wr_ptr] <= dec_imm;
        fmt_q[wr_ptr] <= dec_fmt;
        ill_q[wr_ptr] <= dec_ill;
        tag_q[wr_ptr] <= in_tag;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head entry is presented only while valid so an empty queue reads as zero.
  assign out_imm     = out_valid ? imm_q[rd_ptr] : '0;
  assign out_fmt     = out_valid ? fmt_q[rd_ptr] : '0;
  assign out_illegal = out_valid ? ill_q[rd_ptr] : 1'b0;
  assign out_tag     = out_valid ? tag_q[rd_ptr] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances share stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        rdy64, v64, ill64;
  logic [63:0] imm64;
  logic [4:0]  fmt64;
  logic [31:0] tag64;
  logic        rdy32, v32, ill32;
  logic [31:0] imm32;
  logic [4:0]  fmt32;
  logic [31:0] tag32;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [4:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Check the head of both instances against one expected entry.
  task automatic chk_head(input string name, input logic v, input logic [63:0] imm,
                          input logic [4:0] fmt, input logic ill, input logic [31:0] tag);
    chk({name, ".valid64"}, 64'(v64), 64'(v));
    chk({name, ".imm64"},   imm64, imm);
    chk({name, ".fmt64"},   64'(fmt64), 64'(fmt));
    chk({name, ".ill64"},   64'(ill64), 64'(ill));
    chk({name, ".tag64"},   64'(tag64), 64'(tag));
    chk({name, ".valid32"}, 64'(v32), 64'(v));
    chk({name, ".imm32"},   64'(imm32), 64'(imm[31:0]));
    chk({name, ".fmt32"},   64'(fmt32), 64'(fmt));
    chk({name, ".ill32"},   64'(ill32), 64'(ill));
    chk({name, ".tag32"},   64'(tag32), 64'(tag));
  endtask

  task automatic chk_ready(input string name, input logic exp);
    chk({name, ".rdy64"}, 64'(rdy64), 64'(exp));
    chk({name, ".rdy32"}, 64'(rdy32), 64'(exp));
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] tag);
    @(negedge clk);
    in_valid = v;
    in_inst  = inst;
    in_tag   = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h12345037, 64'h00000000_12345000, 5'b10000, 1'b0};
    vecs[1]  = '{32'h80000037, 64'hFFFFFFFF_80000000, 5'b10000, 1'b0};
    vecs[2]  = '{32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 5'b00100, 1'b0};
    vecs[3]  = '{32'hFFDFF06F, 64'hFFFFFFFF_FFFFFFFC, 5'b01000, 1'b0};
    vecs[4]  = '{32'h00000463, 64'h00000000_00000008, 5'b00010, 1'b0};
    vecs[5]  = '{32'h00000073, 64'h0,                 5'b00000, 1'b1};
    vecs[6]  = '{32'h00000001, 64'h0,                 5'b00000, 1'b1};
    vecs[7]  = '{32'hFE002C23, 64'hFFFFFFFF_FFFFFFF8, 5'b00001, 1'b0};
    vecs[8]  = '{32'h00001017, 64'h00000000_00001000, 5'b10000, 1'b0};
    vecs[9]  = '{32'h7FF02003, 64'h00000000_000007FF, 5'b00100, 1'b0};
    vecs[10] = '{32'h00008067, 64'h0,                 5'b00100, 1'b0};
    vecs[11] = '{32'h0080006F, 64'h00000000_00000008, 5'b01000, 1'b0};
    vecs[12] = '{32'hFE000EE3, 64'hFFFFFFFF_FFFFFFFC, 5'b00010, 1'b0};
    vecs[13] = '{32'h00000033, 64'h0,                 5'b00000, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b0;
    #12;
    chk_head("reset", 1'b0, 64'h0, 5'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_ready("post_reset", 1'b1);

    // Table: push one word, check it one cycle later, pop it on the following edge.
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].inst, 32'h1000 + 32'(i * 4));
      step();
      chk_head($sformatf("vec%0d", i), 1'b1, vecs[i].imm, vecs[i].fmt, vecs[i].ill,
               32'h1000 + 32'(i * 4));
      drive(1'b0, '0, '0);
      step();
      chk_head($sformatf("vec%0d_pop", i), 1'b0, 64'h0, 5'b0, 1'b0, 32'h0);
    end

    // Back-pressure: fill both entries, third word must be held off.
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'h12345037, 32'hA0);
    step();
    chk_ready("bp_after1", 1'b1);
    drive(1'b1, 32'hFFF00093, 32'hA1);
    step();
    chk_ready("bp_after2", 1'b0);
    drive(1'b1, 32'h00000463, 32'hA2);
    step();
    chk_ready("bp_held", 1'b0);
    chk_head("bp_head_stable", 1'b1, 64'h12345000, 5'b10000, 1'b0, 32'hA0);
    @(negedge clk);
    out_ready = 1'b1;
    step();
    chk_head("bp_pop1", 1'b1, 64'hFFFFFFFF_FFFFFFFF, 5'b00100, 1'b0, 32'hA1);
    chk_ready("bp_count1", 1'b1);
    step();
    chk_head("bp_pushpop", 1'b1, 64'h8, 5'b00010, 1'b0, 32'hA2);
    chk_ready("bp_pushpop_rdy", 1'b1);
    drive(1'b0, '0, '0);
    step();
    chk_head("bp_drained", 1'b0, 64'h0, 5'b0, 1'b0, 32'h0);

    // Async reset mid-cycle with two entries queued.
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'h80000037, 32'hB0);
    step();
    drive(1'b1, 32'hFFDFF06F, 32'hB1);
    step();
    chk_head("rst_pre", 1'b1, 64'hFFFFFFFF_80000000, 5'b10000, 1'b0, 32'hB0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_head("rst_async", 1'b0, 64'h0, 5'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_ready("rst_release", 1'b1);
    drive(1'b1, 32'hFE002C23, 32'hC0);
    step();
    chk_head("rst_first", 1'b1, 64'hFFFFFFFF_FFFFFFF8, 5'b00001, 1'b0, 32'hC0);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    step();
    chk_head("rst_drain", 1'b0, 64'h0, 5'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
